maze_renderer: RTL

Raster reader for the maze game's display path: walks every LCD pixel in row-major order, reads the generated maze through the `maze_address`/`maze_address_data` read port, and streams RGB565 pixels to the LCD driver. Each maze cell is a square block of pixels. The player's cell and, optionally, the exit cell are overlaid in distinct colours. It sits between the maze game core (maze RAM read port, player position) and the LT24 pixel-write interface.

---
 rtl/maze_pkg.sv | 21 ++
 rtl/maze_raster_counter.sv | 61 ++++++
 rtl/maze_renderer.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/maze_pkg.sv
// Shared definitions for the maze display path: RGB565 colours, renderer state
// encoding and the default cell size.
package maze_pkg;

  localparam int unsigned RGB565_W        = 16;
  localparam int unsigned MAZE_ADDR_W     = 11;
  localparam int unsigned CELL_PX_DEFAULT = 8;

  localparam logic [RGB565_W-1:0] COLOUR_WALL   = 16'h0000;
  localparam logic [RGB565_W-1:0] COLOUR_PATH   = 16'hFFFF;
  localparam logic [RGB565_W-1:0] COLOUR_PLAYER = 16'hF800;
  localparam logic [RGB565_W-1:0] COLOUR_EXIT   = 16'h07E0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WAIT,
    ST_EMIT
  } render_state_e;

endpackage

// File: rtl/maze_raster_counter.sv
// Row-major pixel position counters for the renderer, exposing the current maze
// cell (column/row) and a flag on the final pixel of the frame.
module maze_raster_counter
  import maze_pkg::*;
#(
  parameter int unsigned WIDTH   = 30,
  parameter int unsigned HEIGHT  = 40,
  parameter int unsigned CELL_PX = CELL_PX_DEFAULT,
  localparam int unsigned SCR_W  = WIDTH * CELL_PX,
  localparam int unsigned SCR_H  = HEIGHT * CELL_PX,
  localparam int unsigned PX_W   = $clog2(SCR_W),
  localparam int unsigned PY_W   = $clog2(SCR_H),
  localparam int unsigned SHIFT  = $clog2(CELL_PX)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  advance,
  input  logic                  clear,
  output logic [PX_W-SHIFT-1:0] cell_col,
  output logic [PY_W-SHIFT-1:0] cell_row,
  output logic                  last_pixel
);

  logic [PX_W-1:0] px_q, px_d;
  logic [PY_W-1:0] py_q, py_d;
  logic            px_at_end;
  logic            py_at_end;

  always_comb begin
    px_at_end = (px_q == PX_W'(SCR_W - 1));
    py_at_end = (py_q == PY_W'(SCR_H - 1));
    px_d      = px_q;
    py_d      = py_q;
    if (clear) begin
      px_d = '0;
      py_d = '0;
    end else if (advance) begin
      if (px_at_end) begin
        px_d = '0;
        py_d = py_at_end ? '0 : py_q + 1'b1;
      end else begin
        px_d = px_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      px_q <= '0;
      py_q <= '0;
    end else begin
      px_q <= px_d;
      py_q <= py_d;
    end
  end

  assign cell_col   = px_q[PX_W-1:SHIFT];
  assign cell_row   = py_q[PY_W-1:SHIFT];
  assign last_pixel = px_at_end && py_at_end;

endmodule

// File: rtl/maze_renderer.sv
// Maze raster renderer: fetch/wait/emit per pixel into the LCD write port.
// Define MAZE_RENDER_EXIT_EN to overlay the exit cell in the EXIT colour.
module maze_renderer
  import maze_pkg::*;
#(
  parameter int unsigned WIDTH   = 30,
  parameter int unsigned HEIGHT  = 40,
  parameter int unsigned CELL_PX = CELL_PX_DEFAULT,
  parameter int unsigned EXIT_X  = 28,
  parameter int unsigned EXIT_Y  = 38
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   render_en,
  input  logic [7:0]             player_x,
  input  logic [7:0]             player_y,
  output logic [MAZE_ADDR_W-1:0] maze_address,
  input  logic                   maze_address_data,
  output logic [RGB565_W-1:0]    pixel_data,
  output logic                   pixel_write,
  input  logic                   pixel_ready,
  output logic                   frame_start,
  output logic                   frame_done
);

  localparam int unsigned PX_W  = $clog2(WIDTH * CELL_PX);
  localparam int unsigned PY_W  = $clog2(HEIGHT * CELL_PX);
  localparam int unsigned SHIFT = $clog2(CELL_PX);
  localparam int unsigned COL_W = PX_W - SHIFT;
  localparam int unsigned ROW_W = PY_W - SHIFT;

  render_state_e          state_q, state_d;
  logic [7:0]             plx_q, plx_d;
  logic [7:0]             ply_q, ply_d;
  logic [MAZE_ADDR_W-1:0] maze_address_q, maze_address_d;
  logic [RGB565_W-1:0]    pixel_data_q, pixel_data_d;
  logic                   pixel_write_q, pixel_write_d;
  logic                   frame_start_q, frame_start_d;

  logic                   advance;
  logic                   clear;
  logic [COL_W-1:0]       cell_col;
  logic [ROW_W-1:0]       cell_row;
  logic                   last_pixel;
  logic [MAZE_ADDR_W-1:0] cell_addr;
  logic                   player_hit;
  logic                   exit_hit;
  logic [RGB565_W-1:0]    colour;

  maze_raster_counter #(
    .WIDTH   (WIDTH),
    .HEIGHT  (HEIGHT),
    .CELL_PX (CELL_PX)
  ) u_counter (
    .clock      (clock),
    .reset      (reset),
    .advance    (advance),
    .clear      (clear),
    .cell_col   (cell_col),
    .cell_row   (cell_row),
    .last_pixel (last_pixel)
  );

  always_comb begin
    cell_addr  = MAZE_ADDR_W'(cell_row) * MAZE_ADDR_W'(WIDTH) + MAZE_ADDR_W'(cell_col);
    // An out-of-maze latched position can never equal a live cell index.
    player_hit = (plx_q == 8'(cell_col)) && (ply_q == 8'(cell_row));
`ifdef MAZE_RENDER_EXIT_EN
    exit_hit   = (cell_col == COL_W'(EXIT_X)) && (cell_row == ROW_W'(EXIT_Y));
`else
    exit_hit   = 1'b0;
`endif
    if (player_hit)             colour = COLOUR_PLAYER;
    else if (exit_hit)          colour = COLOUR_EXIT;
    else if (maze_address_data) colour = COLOUR_WALL;
    else                        colour = COLOUR_PATH;
  end

  always_comb begin
    state_d        = state_q;
    plx_d          = plx_q;
    ply_d          = ply_q;
    maze_address_d = maze_address_q;
    pixel_data_d   = pixel_data_q;
    pixel_write_d  = pixel_write_q;
    frame_start_d  = 1'b0;
    advance        = 1'b0;
    clear          = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (render_en) begin
          state_d       = ST_FETCH;
          clear         = 1'b1;
          plx_d         = player_x;
          ply_d         = player_y;
          frame_start_d = 1'b1;
        end
      end
      ST_FETCH: begin
        maze_address_d = cell_addr;
        state_d        = ST_WAIT;
      end
      ST_WAIT: begin
        pixel_data_d  = colour;
        pixel_write_d = 1'b1;
        state_d       = ST_EMIT;
      end
      ST_EMIT: begin
        if (pixel_ready) begin
          pixel_write_d = 1'b0;
          advance       = 1'b1;
          if (!last_pixel) begin
            state_d = ST_FETCH;
          end else if (render_en) begin
            state_d       = ST_FETCH;
            clear         = 1'b1;
            plx_d         = player_x;
            ply_d         = player_y;
            frame_start_d = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      plx_q          <= '0;
      ply_q          <= '0;
      maze_address_q <= '0;
      pixel_data_q   <= '0;
      pixel_write_q  <= 1'b0;
      frame_start_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      plx_q          <= plx_d;
      ply_q          <= ply_d;
      maze_address_q <= maze_address_d;
      pixel_data_q   <= pixel_data_d;
      pixel_write_q  <= pixel_write_d;
      frame_start_q  <= frame_start_d;
    end
  end

  assign maze_address = maze_address_q;
  assign pixel_data   = pixel_data_q;
  assign pixel_write  = pixel_write_q;
  assign frame_start  = frame_start_q;
  // Decoded from registered state so it coincides with the final transfer cycle.
  assign frame_done   = (state_q == ST_EMIT) && last_pixel && pixel_ready;

endmodule
